mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative multiply/divide unit owning the HI/LO register pair that the ALU leaves unused.
//  Sits beside the ALU in EX and completes MULT/MULTU/DIV/DIVU over several cycles.
//  Raises busy so hazard logic stalls dependent mfhi/mflo.
//  Exposes hi/lo for mfhi/mflo read-back and accepts mthi/mtlo writes.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count = WIDTH; counter = $clog2(WIDTH)+1 bits
// PORTS
//  clk     in   1      rising-edge clock
//  reset   in   1      asynchronous, active-low reset
//  start   in   1      request op; accepted only when busy=0
//  op      in   2      00 MULT(signed) 01 MULTU 10 DIV(signed) 11 DIVU
//  a       in   WIDTH  multiplicand / dividend (rs)
//  b       in   WIDTH  multiplier / divisor (rt)
//  we_hi   in   1      mthi: write wd into hi
//  we_lo   in   1      mtlo: write wd into lo
//  wd      in   WIDTH  mthi/mtlo write data
//  busy    out  1      operation in flight
//  done    out  1      one-cycle pulse when hi/lo take a result
//  hi      out  WIDTH  HI register (product upper half / remainder)
//  lo      out  WIDTH  LO register (product lower half / quotient)
// BEHAVIOUR
//  - Reset (reset=0, async): hi=0, lo=0, busy=0, done=0, state IDLE, counter=0.
//    Reset mid-operation aborts it; no done pulse follows.
//  - States:
//    - IDLE -> RUN on an edge with start=1.
//    - RUN stays RUN for WIDTH edges, then returns to IDLE, writing hi/lo and pulsing done.
//  - Acceptance: at the accepting edge, latch op, |a|, |b| and the result signs.
//    Later changes on a/b/op are ignored. start while busy=1 is ignored (no queueing).
//  - Latency:
//    - busy=1 for exactly WIDTH cycles after the accepting edge.
//    - At the WIDTH-th edge: hi/lo update, busy->0, done=1 for one cycle.
//    - start is accepted in the done cycle (back-to-back issue allowed).
//  - Multiply: shift-add, one partial product per cycle, 2*WIDTH product {hi,lo}.
//    Signed mode negates the product when operand signs differ.
//  - Divide: restoring, one quotient bit per cycle; lo=quotient, hi=remainder.
//    - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
//    - b=0 (signed or unsigned): still WIDTH cycles; result lo=all-ones, hi=a.
//    - DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
//  - mthi/mtlo:
//    - Write wd at the next edge only when busy=0.
//    - Ignored while busy=1.
//    - we_hi/we_lo with start on the same edge: write happens; the op result later overwrites.
//    - A result write and an mthi/mtlo write on the same edge cannot occur (busy gates it).
//  - hi/lo are registered outputs; they hold their previous values while busy.
// CONFIGURATION
//  MDU_FAST_MULT_EN
//   - Defined: MULT/MULTU use a single-cycle array multiply (*). Result written at the
//     accepting edge+1 (done pulses the cycle after acceptance); busy never asserts for
//     multiplies. Divides unchanged.
//   - Undefined: multiplies use the WIDTH-cycle shift-add path described above.
// TESTING
//  1. MULT a=0xFFFFFFFD(-3) b=7 -> busy 32 cycles, done pulse; hi=0xFFFFFFFF lo=0xFFFFFFEB.
//  2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001.
//  3. DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU a=7 b=2 -> lo=3 hi=1.
//  4. DIV a=5 b=0 -> lo=0xFFFFFFFF hi=5; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
//  5. Contention and abort:
//     - start and we_hi(wd=0x1234) while busy -> both ignored, original result lands.
//     - Idle we_lo wd=0xABCD -> lo=0xABCD next cycle.
//     - reset=0 at cycle 10 of DIV -> busy=0 hi=lo=0, no done.
//  6. Back-to-back and fast mode:
//     - start in the done cycle -> next op accepted with no gap.
//     - With MDU_FAST_MULT_EN, MULTU 6*7 -> done the next cycle, lo=42 hi=0, busy stays 0.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one shift-add or restoring step per cycle.
// Optional MDU_FAST_MULT_EN: single-cycle array multiply for MULT/MULTU.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic             is_div, neg_q, neg_r, bzero, done_q;
  logic [WIDTH-1:0] opb, p_hi, p_lo;

  // op[0]=0 selects the signed variants
  logic             sa, sb, accept, last, fast_mul;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign sa     = ~op[0] & a[WIDTH-1];
  assign sb     = ~op[0] & b[WIDTH-1];
  assign abs_a  = sa ? -a : a;
  assign abs_b  = sb ? -b : b;
  assign accept = start && (state == IDLE);
  assign last   = (state == RUN) && (cnt == CW'(WIDTH-1));

`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
  assign fast_mul  = ~op[1];
  assign ext_a     = op[0] ? {{WIDTH{1'b0}}, a} : {{WIDTH{a[WIDTH-1]}}, a};
  assign ext_b     = op[0] ? {{WIDTH{1'b0}}, b} : {{WIDTH{b[WIDTH-1]}}, b};
  assign fast_prod = ext_a * ext_b;
`else
  assign fast_mul = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !fast_mul) state_nxt = RUN;
      RUN:  if (last)               state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == RUN);
    done = done_q;
  end

  // One iteration: p_hi is partial product / remainder, p_lo is multiplier / dividend-quotient
  logic [WIDTH:0]   mul_sum, shifted;
  logic [WIDTH-1:0] diff, step_hi, step_lo;
  logic             sub_ok;
  always_comb begin
    mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opb} : '0);
    shifted = {p_hi, p_lo[WIDTH-1]};
    sub_ok  = shifted >= {1'b0, opb};
    diff    = shifted[WIDTH-1:0] - opb;
    if (is_div) begin
      step_hi = sub_ok ? diff : shifted[WIDTH-1:0];
      step_lo = {p_lo[WIDTH-2:0], sub_ok};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], p_lo[WIDTH-1:1]};
    end
  end

  // Sign correction; a zero divisor leaves the remainder equal to the dividend
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;
  always_comb begin
    prod = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    if (is_div) begin
      res_lo = bzero ? '1 : (neg_q ? -step_lo : step_lo);
      res_hi = neg_r ? -step_hi : step_hi;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0; is_div <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0; bzero <= 1'b0;
      opb <= '0; p_hi <= '0; p_lo <= '0;
    end else if (accept) begin
      cnt    <= '0;
      is_div <= op[1];
      neg_q  <= sa ^ sb;
      neg_r  <= sa;
      bzero  <= (b == '0);
      opb    <= abs_b;
      p_hi   <= '0;
      p_lo   <= abs_a;
    end else if (state == RUN) begin
      cnt  <= last ? '0 : cnt + 1'b1;
      p_hi <= step_hi;
      p_lo <= step_lo;
    end
  end

  // HI/LO: result write has priority; mthi/mtlo only while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0; lo <= '0; done_q <= 1'b0;
    end else begin
      done_q <= last || (accept && fast_mul);
      if (last) begin
        hi <= res_hi;
        lo <= res_lo;
`ifdef MDU_FAST_MULT_EN
      end else if (accept && fast_mul) begin
        hi <= fast_prod[2*WIDTH-1:WIDTH];
        lo <= fast_prod[WIDTH-1:0];
`endif
      end else if (state == IDLE) begin
        if (we_hi) hi <= wd;
        if (we_lo) lo <= wd;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed vector bench for mul_div_unit: table of ops plus contention, mthi/mtlo and reset-abort sequences.
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0, reset = 1'b0, start = 1'b0, we_hi = 1'b0, we_lo = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0, wd = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .we_hi(we_hi), .we_lo(we_lo), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, hi, lo;
  } vec_t;

  int nvec = 0, nerr = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] o);
`ifdef MDU_FAST_MULT_EN
    return o[1] ? W : 0;
`else
    return W;
`endif
  endfunction

  // Called right after a negedge; issues immediately so consecutive calls are back-to-back.
  // poke>=0: at that busy cycle, drive a rival start plus mthi which must be ignored.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int poke, output int lat, output bit dn);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0000_0003; op = ~o;
    lat = 0; dn = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == poke) begin
        start = 1'b1; op = 2'b11; we_hi = 1'b1; wd = 32'h1234;
      end else begin
        start = 1'b0; we_hi = 1'b0;
      end
      if (done) begin dn = 1'b1; break; end
      if (busy) lat++;
    end
    start = 1'b0; we_hi = 1'b0;
  endtask

  vec_t tbl[14];
  int   lat;
  bit   dn;
  bit   saw_done;

  initial begin
    tbl[0]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3]  = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    tbl[4]  = '{2'b10, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    tbl[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[6]  = '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    tbl[7]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    tbl[8]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    tbl[9]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    tbl[10] = '{2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    tbl[11] = '{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    tbl[12] = '{2'b01, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    tbl[13] = '{2'b01, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A};

    // Reset state
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    // Table: every op issued in the previous op's done cycle
    for (int i = 0; i < 14; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, -1, lat, dn);
      chk($sformatf("v%0d_done", i), {31'b0, dn}, 32'd1);
      chk($sformatf("v%0d_lat", i), lat, exp_lat(tbl[i].op));
      chk($sformatf("v%0d_hi", i), hi, tbl[i].hi);
      chk($sformatf("v%0d_lo", i), lo, tbl[i].lo);
    end
    @(negedge clk);
    chk("done_pulse_width", {31'b0, done}, 32'd0);
    chk("idle_busy", {31'b0, busy}, 32'd0);

    // Rival start and mthi while busy are dropped
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 5, lat, dn);
    chk("cont_lat", lat, exp_lat(2'b00));
    chk("cont_hi", hi, 32'hFFFF_FFFF);
    chk("cont_lo", lo, 32'hFFFF_FFEB);
    @(negedge clk);
    chk("cont_no_queue", {31'b0, busy}, 32'd0);

    // Idle mtlo / mthi
    we_lo = 1'b1; wd = 32'hABCD;
    @(posedge clk); #1 we_lo = 1'b0;
    chk("mtlo_lo", lo, 32'hABCD);
    chk("mtlo_hi_kept", hi, 32'hFFFF_FFFF);
    @(negedge clk);
    we_hi = 1'b1; wd = 32'h5555_0000;
    @(posedge clk); #1 we_hi = 1'b0;
    chk("mthi_hi", hi, 32'h5555_0000);

    // mthi alongside start: written now, overwritten by the result
    @(negedge clk);
    we_hi = 1'b1; wd = 32'h0BAD_F00D;
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; we_hi = 1'b0;
    chk("mthi_with_start", hi, 32'h0BAD_F00D);
    saw_done = 1'b0;
    for (int i = 0; i < 100 && !saw_done; i++) begin
      @(negedge clk);
      saw_done = done;
    end
    chk("mthi_start_done", {31'b0, saw_done}, 32'd1);
    chk("mthi_start_hi", hi, 32'd2);
    chk("mthi_start_lo", lo, 32'd14);

    // Reset 10 cycles into a DIV aborts it with no done
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk); reset = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort_no_done", {31'b0, saw_done}, 32'd0);
    chk("abort_lo_held", lo, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
